// File: rtl/lru_cam.sv
// Fully registered CAM with true-LRU replacement, invalidate, multi-cycle flush
// and valid/ready handshakes on both the request and the response side.
module lru_cam #(
    parameter int CAMSIZE = 8,
    parameter int KEY_W   = 16,
    parameter int VAL_W   = 32,
    localparam int IDX_W  = $clog2(CAMSIZE)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [KEY_W-1:0] req_key_i,
    input  logic [VAL_W-1:0] req_val_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_hit_o,
    output logic [VAL_W-1:0] resp_val_o,
    output logic [IDX_W-1:0] resp_idx_o,
    output logic             resp_evict_o,
    output logic [KEY_W-1:0] resp_evict_key_o,
    output logic [VAL_W-1:0] resp_evict_val_o,
    output logic [IDX_W:0]   count_o
);
    typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_INV = 2'b10, OP_FLUSH = 2'b11} op_e;
    typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_e;

    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(CAMSIZE - 1);
    localparam logic [IDX_W:0]   FULL    = (IDX_W + 1)'(CAMSIZE);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     flush_idx_q, flush_idx_d;
    logic [CAMSIZE-1:0]   valid_q, valid_d;
    logic [IDX_W-1:0]     age_q [CAMSIZE];
    logic [IDX_W-1:0]     age_d [CAMSIZE];
    logic [KEY_W-1:0]     key_q [CAMSIZE];
    logic [KEY_W-1:0]     key_d [CAMSIZE];
    logic [VAL_W-1:0]     val_q [CAMSIZE];
    logic [VAL_W-1:0]     val_d [CAMSIZE];
    logic [IDX_W:0]       count_q, count_d;

    logic                 rvalid_q, rvalid_d, rhit_q, rhit_d, revict_q, revict_d;
    logic [VAL_W-1:0]     rval_q, rval_d, revval_q, revval_d;
    logic [IDX_W-1:0]     ridx_q, ridx_d;
    logic [KEY_W-1:0]     revkey_q, revkey_d;

    logic [CAMSIZE-1:0]   match;
    logic                 hit;
    logic [IDX_W-1:0]     hit_idx, free_idx, lru_idx, tgt_idx, hit_age;
    logic                 full, accept;

    assign req_ready_o      = (state_q == S_IDLE) && (!rvalid_q || resp_ready_i);
    assign accept           = req_valid_i && req_ready_o;
    assign full             = (count_q == FULL);
    assign resp_valid_o     = rvalid_q;
    assign resp_hit_o       = rhit_q;
    assign resp_val_o       = rval_q;
    assign resp_idx_o       = ridx_q;
    assign resp_evict_o     = revict_q;
    assign resp_evict_key_o = revkey_q;
    assign resp_evict_val_o = revval_q;
    assign count_o          = count_q;

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        lru_idx  = '0;
        for (int i = CAMSIZE - 1; i >= 0; i--) begin
            match[i] = valid_q[i] && (key_q[i] == req_key_i);
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid_q[i]) free_idx = IDX_W'(i);
            if (valid_q[i] && age_q[i] == AGE_MAX) lru_idx = IDX_W'(i);
        end
    end

    assign hit_age = age_q[hit_idx];
    assign tgt_idx = full ? lru_idx : free_idx;

    always_comb begin
        state_d     = state_q;
        flush_idx_d = flush_idx_q;
        valid_d     = valid_q;
        age_d       = age_q;
        key_d       = key_q;
        val_d       = val_q;
        count_d     = count_q;
        rvalid_d    = rvalid_q && !resp_ready_i;
        rhit_d      = rhit_q;
        rval_d      = rval_q;
        ridx_d      = ridx_q;
        revict_d    = revict_q;
        revkey_d    = revkey_q;
        revval_d    = revval_q;

        if (state_q == S_FLUSH) begin
            valid_d[flush_idx_q] = 1'b0;
            age_d[flush_idx_q]   = AGE_MAX;
            if (valid_q[flush_idx_q]) count_d = count_q - 1'b1;
            flush_idx_d = flush_idx_q + 1'b1;
            if (flush_idx_q == AGE_MAX) begin
                state_d  = S_IDLE;
                rvalid_d = 1'b1;
                rhit_d   = 1'b0;
                rval_d   = '0;
                ridx_d   = '0;
                revict_d = 1'b0;
                revkey_d = '0;
                revval_d = '0;
            end
        end else if (accept) begin
            rhit_d   = 1'b0;
            rval_d   = '0;
            ridx_d   = '0;
            revict_d = 1'b0;
            revkey_d = '0;
            revval_d = '0;
            if (req_op_i != OP_FLUSH) rvalid_d = 1'b1;
            case (op_e'(req_op_i))
                OP_READ, OP_WRITE: begin
                    if (hit) begin
                        for (int i = 0; i < CAMSIZE; i++)
                            if (valid_q[i] && age_q[i] < hit_age) age_d[i] = age_q[i] + 1'b1;
                        age_d[hit_idx] = '0;
                        rhit_d = 1'b1;
                        ridx_d = hit_idx;
                        if (req_op_i == OP_WRITE) val_d[hit_idx] = req_val_i;
                        else rval_d = val_q[hit_idx];
                    end else if (req_op_i == OP_WRITE) begin
                        for (int i = 0; i < CAMSIZE; i++)
                            if (valid_q[i] && IDX_W'(i) != tgt_idx) age_d[i] = age_q[i] + 1'b1;
                        valid_d[tgt_idx] = 1'b1;
                        key_d[tgt_idx]   = req_key_i;
                        val_d[tgt_idx]   = req_val_i;
                        age_d[tgt_idx]   = '0;
                        ridx_d           = tgt_idx;
                        if (full) begin
                            revict_d = 1'b1;
                            revkey_d = key_q[tgt_idx];
                            revval_d = val_q[tgt_idx];
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                OP_INV: begin
                    if (hit) begin
                        for (int i = 0; i < CAMSIZE; i++)
                            if (valid_q[i] && age_q[i] > hit_age) age_d[i] = age_q[i] - 1'b1;
                        valid_d[hit_idx] = 1'b0;
                        age_d[hit_idx]   = AGE_MAX;
                        count_d          = count_q - 1'b1;
                        rhit_d           = 1'b1;
                        ridx_d           = hit_idx;
                    end
                end
                default: begin
                    state_d     = S_FLUSH;
                    flush_idx_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            flush_idx_q <= '0;
            valid_q     <= '0;
            count_q     <= '0;
            for (int i = 0; i < CAMSIZE; i++) age_q[i] <= AGE_MAX;
            rvalid_q    <= 1'b0;
            rhit_q      <= 1'b0;
            rval_q      <= '0;
            ridx_q      <= '0;
            revict_q    <= 1'b0;
            revkey_q    <= '0;
            revval_q    <= '0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            age_q       <= age_d;
            rvalid_q    <= rvalid_d;
            rhit_q      <= rhit_d;
            rval_q      <= rval_d;
            ridx_q      <= ridx_d;
            revict_q    <= revict_d;
            revkey_q    <= revkey_d;
            revval_q    <= revval_d;
        end
    end

    // Key/value storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        key_q <= key_d;
        val_q <= val_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && accept) assert ($onehot0(match));
    end
endmodule

// File: tb/tb_lru_cam.sv
// Scoreboard bench for lru_cam (CAMSIZE=4, KEY_W=8, VAL_W=16) with directed vectors.
module tb_lru_cam;
    localparam int CAMSIZE = 4;
    localparam int KEY_W   = 8;
    localparam int VAL_W   = 16;
    localparam int IDX_W   = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [KEY_W-1:0] req_key = '0;
    logic [VAL_W-1:0] req_val = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b1;
    logic             resp_hit;
    logic [VAL_W-1:0] resp_val;
    logic [IDX_W-1:0] resp_idx;
    logic             resp_evict;
    logic [KEY_W-1:0] resp_evict_key;
    logic [VAL_W-1:0] resp_evict_val;
    logic [IDX_W:0]   count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic             hit;
        logic [VAL_W-1:0] val;
        logic [IDX_W-1:0] idx;
        logic             ev;
        logic [KEY_W-1:0] ekey;
        logic [VAL_W-1:0] eval;
        logic [IDX_W:0]   cnt;
    } exp_t;

    exp_t q[$];
    exp_t e_m;

    lru_cam #(.CAMSIZE(CAMSIZE), .KEY_W(KEY_W), .VAL_W(VAL_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_key_i(req_key), .req_val_i(req_val),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_hit_o(resp_hit), .resp_val_o(resp_val), .resp_idx_o(resp_idx),
        .resp_evict_o(resp_evict), .resp_evict_key_o(resp_evict_key),
        .resp_evict_val_o(resp_evict_val), .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_resp(input logic hit, input logic [VAL_W-1:0] val, input logic [IDX_W-1:0] idx,
                               input logic ev, input logic [KEY_W-1:0] ekey, input logic [VAL_W-1:0] eval,
                               input logic [IDX_W:0] cnt);
        exp_t e;
        e.hit = hit; e.val = val; e.idx = idx; e.ev = ev; e.ekey = ekey; e.eval = eval; e.cnt = cnt;
        q.push_back(e);
    endtask

    // Returns 1 time unit after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [KEY_W-1:0] key, input logic [VAL_W-1:0] v);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_key = key; req_val = v;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: req_ready_o stayed 0, expected 1 within 20 cycles");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_resp: response seen, none expected at %0t", $time);
            end else begin
                e_m = q.pop_front();
                chk("resp_hit", 32'(resp_hit), 32'(e_m.hit));
                chk("resp_val", 32'(resp_val), 32'(e_m.val));
                chk("resp_idx", 32'(resp_idx), 32'(e_m.idx));
                chk("resp_evict", 32'(resp_evict), 32'(e_m.ev));
                chk("evict_key", 32'(resp_evict_key), 32'(e_m.ekey));
                chk("evict_val", 32'(resp_evict_val), 32'(e_m.eval));
                chk("count", 32'(count), 32'(e_m.cnt));
            end
        end
    end

    initial begin
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: fill all four entries
        for (int i = 0; i < 4; i++) begin
            expect_resp(1'b0, 16'h0, IDX_W'(i), 1'b0, 8'h0, 16'h0, (IDX_W + 1)'(i + 1));
            issue(2'b01, 8'(8'h10 * (i + 1)), 16'(16'hA000 + i));
        end

        // 2: read promotes 0x10, so 0x20 becomes the victim
        expect_resp(1'b1, 16'hA000, 2'd0, 1'b0, 8'h0, 16'h0, 3'd4);
        issue(2'b00, 8'h10, 16'h0);
        expect_resp(1'b0, 16'h0, 2'd1, 1'b1, 8'h20, 16'hA001, 3'd4);
        issue(2'b01, 8'h50, 16'hB000);

        // 3: invalidate frees a slot that the next write fills
        expect_resp(1'b1, 16'h0, 2'd2, 1'b0, 8'h0, 16'h0, 3'd3);
        issue(2'b10, 8'h30, 16'h0);
        expect_resp(1'b0, 16'h0, 2'd2, 1'b0, 8'h0, 16'h0, 3'd4);
        issue(2'b01, 8'h60, 16'hC000);
        expect_resp(1'b0, 16'h0, 2'd0, 1'b0, 8'h0, 16'h0, 3'd4);
        issue(2'b00, 8'h30, 16'h0);
        expect_resp(1'b0, 16'h0, 2'd0, 1'b0, 8'h0, 16'h0, 3'd4);
        issue(2'b10, 8'h99, 16'h0);

        // 4: response back-pressure
        repeat (2) @(negedge clk);
        resp_ready = 1'b0;
        expect_resp(1'b1, 16'hA003, 2'd3, 1'b0, 8'h0, 16'h0, 3'd4);
        issue(2'b00, 8'h40, 16'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_resp_val", 32'(resp_val), 32'hA003);
            chk("bp_resp_idx", 32'(resp_idx), 32'd3);
            chk("bp_resp_hit", 32'(resp_hit), 32'd1);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("bp_consumed", 32'(resp_valid), 32'd0);

        // 5: flush takes CAMSIZE cycles then responds once
        expect_resp(1'b0, 16'h0, 2'd0, 1'b0, 8'h0, 16'h0, 3'd0);
        issue(2'b11, 8'h0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("flush_req_ready", 32'(req_ready), 32'd0);
        end
        chk("flush_no_early_resp", 32'(resp_valid), 32'd0);
        expect_resp(1'b0, 16'h0, 2'd0, 1'b0, 8'h0, 16'h0, 3'd0);
        issue(2'b00, 8'h10, 16'h0);
        expect_resp(1'b0, 16'h0, 2'd0, 1'b0, 8'h0, 16'h0, 3'd1);
        issue(2'b01, 8'h10, 16'hD000);
        expect_resp(1'b1, 16'h0, 2'd0, 1'b0, 8'h0, 16'h0, 3'd1);
        issue(2'b01, 8'h10, 16'hD111);
        expect_resp(1'b1, 16'hD111, 2'd0, 1'b0, 8'h0, 16'h0, 3'd1);
        issue(2'b00, 8'h10, 16'h0);
        expect_resp(1'b0, 16'h0, 2'd1, 1'b0, 8'h0, 16'h0, 3'd2);
        issue(2'b01, 8'h20, 16'hE000);

        // 6: asynchronous reset in the middle of a flush
        issue(2'b11, 8'h0, 16'h0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midflush_resp_valid", 32'(resp_valid), 32'd0);
        chk("midflush_count", 32'(count), 32'd0);
        chk("midflush_resp_hit", 32'(resp_hit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_ready", 32'(req_ready), 32'd1);
        repeat (8) @(negedge clk);
        chk("no_flush_resp", 32'(resp_valid), 32'd0);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish, expected end before 50000");
        $fatal(1);
    end
endmodule
